// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issue/write-back controller for a 16-bit combinational ALU. It accepts one
//   instruction at a time, reads operands from a 4 x 16 register file, drives
//   registered ALU inputs, captures the ALU result and flags back into the
//   register file, and presents each result downstream with backpressure.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
//   valid and ready are both high. The producer may change or drop its payload
//   freely while ready is low. instr_ready and res_valid are pure decodes of the
//   FSM state, so neither has a combinational path from any input.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   instr_valid/instr_ready instruction handshake (ready only in IDLE)
//   instr[15:0]             [15] ld, [14:12] op, [11:10] rd, [9:8] ra,
//                           [7:6] rb, [5] cin, [4:0] reserved
//   imm[15:0]               load value, used when ld=1
//   alu_a, alu_b, alu_c,    registered ALU operands / carry-in / opcode
//   alu_op
//   alu_w, alu_zero, alu_neg ALU result and flags
//   res_valid/res_ready     result handshake
//   res_data, res_zero,     result value as written to R[rd] and its flags
//   res_neg
//   dbg_sel, dbg_data       combinational register file read port
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  input  logic [15:0] imm,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_c,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_w,
  input  logic        alu_zero,
  input  logic        alu_neg,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_zero,
  output logic        res_neg,
  input  logic [1:0]  dbg_sel,
  output logic [15:0] dbg_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state;
  logic [1:0]  rd_q;   // destination held across ISSUE/EXEC
  logic [15:0] rf [4];

  logic       f_ld;
  logic [2:0] f_op;
  logic [1:0] f_rd;
  logic [1:0] f_ra;
  logic [1:0] f_rb;
  logic       f_cin;
  logic       unused_reserved;

  assign f_ld  = instr[15];
  assign f_op  = instr[14:12];
  assign f_rd  = instr[11:10];
  assign f_ra  = instr[9:8];
  assign f_rb  = instr[7:6];
  assign f_cin = instr[5];
  assign unused_reserved = ^instr[4:0];

  assign instr_ready = (state == S_IDLE);
  assign res_valid   = (state == S_DONE);
  assign dbg_data    = rf[dbg_sel];

  // The register file is written only here: once at accept for a load, once
  // in EXEC for an ALU op. Operands are captured at accept, so rd may alias
  // ra/rb without hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rd_q     <= 2'd0;
      alu_a    <= 16'd0;
      alu_b    <= 16'd0;
      alu_c    <= 1'b0;
      alu_op   <= 3'd7;
      res_data <= 16'd0;
      res_zero <= 1'b0;
      res_neg  <= 1'b0;
      for (int i = 0; i < 4; i++) rf[i] <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            rd_q <= f_rd;
            if (f_ld) begin
              rf[f_rd] <= imm;
              res_data <= imm;
              res_zero <= (imm == 16'd0);
              res_neg  <= imm[15];
              state    <= S_DONE;
            end else begin
              alu_a  <= rf[f_ra];
              alu_b  <= rf[f_rb];
              alu_op <= f_op;
              alu_c  <= f_cin;
              state  <= S_ISSUE;
            end
          end
        end
        // ALU inputs settle for a full cycle before the result is sampled.
        S_ISSUE: state <= S_EXEC;
        S_EXEC: begin
          rf[rd_q] <= alu_w;
          res_data <= alu_w;
          res_zero <= alu_zero;
          res_neg  <= alu_neg;
          state    <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] imm;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_c;
  logic [2:0]  alu_op;
  logic [15:0] alu_w;
  logic        alu_zero;
  logic        alu_neg;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_zero;
  logic        res_neg;
  logic [1:0]  dbg_sel;
  logic [15:0] dbg_data;

  int checks;
  int failures;
  int n;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .imm(imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_op(alu_op),
    .alu_w(alu_w), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero), .res_neg(res_neg),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU the controller drives.
  logic signed [15:0] b_s;
  always_comb begin
    b_s = alu_b;
    case (alu_op)
      3'd0:    alu_w = ~alu_a + 16'd1;
      3'd1:    alu_w = alu_a + 16'd1;
      3'd2:    alu_w = alu_a + alu_b + {15'd0, alu_c};
      3'd3:    alu_w = alu_a + 16'(b_s >>> 1);
      3'd4:    alu_w = alu_a & alu_b;
      3'd5:    alu_w = alu_a | alu_b;
      3'd6:    alu_w = {alu_a[7:0], alu_b[7:0]};
      default: alu_w = 16'd0;
    endcase
    alu_zero = (alu_w == 16'd0);
    alu_neg  = alu_w[15];
  end

  function automatic logic [15:0] mk(input logic ld, input logic [2:0] op,
                                     input logic [1:0] rd, input logic [1:0] ra,
                                     input logic [1:0] rb, input logic cin);
    return {ld, op, rd, ra, rb, cin, 5'b0};
  endfunction

  // drivers: all tasks start and end 1 time unit after a rising edge
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [15:0] ins, input logic [15:0] value);
    int k;
    k = 0;
    while (!instr_ready && k < 20) begin step(); k++; end
    instr = ins; imm = value; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0; instr = 16'hFFFF; imm = 16'hDEAD;
  endtask

  // Edges waited until res_valid; -1 when the bound expires.
  task automatic wait_res(output int cnt);
    cnt = 0;
    while (!res_valid && cnt < 20) begin step(); cnt++; end
    if (!res_valid) cnt = -1;
  endtask

  task automatic retire();
    res_ready = 1'b1; step(); res_ready = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0; #3;
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_instr_ready got=%b exp=1", instr_ready); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    checks++; if (alu_op !== 3'd7 || alu_a !== 16'd0 || alu_b !== 16'd0 || alu_c !== 1'b0) begin
      failures++; $display("FAIL reset_alu_in got op=%0d a=%h b=%h c=%b exp op=7 a=0 b=0 c=0", alu_op, alu_a, alu_b, alu_c); end
    checks++; if (res_data !== 16'd0 || res_zero !== 1'b0 || res_neg !== 1'b0) begin
      failures++; $display("FAIL reset_res got=%h z=%b n=%b exp=0000 z=0 n=0", res_data, res_zero, res_neg); end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      checks++; if (dbg_data !== 16'd0) begin failures++; $display("FAIL reset_rf%0d got=%h exp=0000", i, dbg_data); end
    end
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_load();
    issue(mk(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0), 16'h0005);
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL ld1_latency res_valid got=%b exp=1", res_valid); end
    checks++; if (res_data !== 16'h0005 || res_zero !== 1'b0 || res_neg !== 1'b0) begin
      failures++; $display("FAIL ld1_data got=%h z=%b n=%b exp=0005 z=0 n=0", res_data, res_zero, res_neg); end
    retire();
    checks++; if (instr_ready !== 1'b1 || res_valid !== 1'b0) begin
      failures++; $display("FAIL ld1_retire ready=%b valid=%b exp ready=1 valid=0", instr_ready, res_valid); end
    issue(mk(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 1'b0), 16'h0003);
    checks++; if (res_valid !== 1'b1 || res_data !== 16'h0003) begin
      failures++; $display("FAIL ld2 valid=%b data=%h exp valid=1 data=0003", res_valid, res_data); end
    retire();
    dbg_sel = 2'd1; #1;
    checks++; if (dbg_data !== 16'h0005) begin failures++; $display("FAIL ld_dbg_r1 got=%h exp=0005", dbg_data); end
  endtask

  task automatic test_add();
    issue(mk(1'b0, 3'd2, 2'd3, 2'd1, 2'd2, 1'b1), 16'h0000);
    checks++; if (res_valid !== 1'b0 || instr_ready !== 1'b0) begin
      failures++; $display("FAIL add_issue valid=%b ready=%b exp valid=0 ready=0", res_valid, instr_ready); end
    checks++; if (alu_op !== 3'd2 || alu_a !== 16'h0005 || alu_b !== 16'h0003 || alu_c !== 1'b1) begin
      failures++; $display("FAIL add_alu_in op=%0d a=%h b=%h c=%b exp op=2 a=0005 b=0003 c=1", alu_op, alu_a, alu_b, alu_c); end
    step();
    checks++; if (res_valid !== 1'b0 || alu_op !== 3'd2) begin
      failures++; $display("FAIL add_exec valid=%b op=%0d exp valid=0 op=2", res_valid, alu_op); end
    step();
    checks++; if (res_valid !== 1'b1 || res_data !== 16'h0009 || res_zero !== 1'b0 || res_neg !== 1'b0) begin
      failures++; $display("FAIL add_result valid=%b data=%h z=%b n=%b exp valid=1 data=0009 z=0 n=0", res_valid, res_data, res_zero, res_neg); end
    retire();
    dbg_sel = 2'd3; #1;
    checks++; if (dbg_data !== 16'h0009) begin failures++; $display("FAIL add_dbg_r3 got=%h exp=0009", dbg_data); end
  endtask

  task automatic test_neg_pack();
    issue(mk(1'b0, 3'd0, 2'd1, 2'd1, 2'd0, 1'b0), 16'h0000);
    wait_res(n);
    checks++; if (n !== 2) begin failures++; $display("FAIL neg_latency got=%0d exp=2", n); end
    checks++; if (res_data !== 16'hFFFB || res_neg !== 1'b1 || res_zero !== 1'b0) begin
      failures++; $display("FAIL neg_result data=%h z=%b n=%b exp data=FFFB z=0 n=1", res_data, res_zero, res_neg); end
    retire();
    issue(mk(1'b0, 3'd6, 2'd0, 2'd2, 2'd1, 1'b0), 16'h0000);
    wait_res(n);
    checks++; if (n !== 2 || res_data !== 16'h03FB || res_neg !== 1'b0) begin
      failures++; $display("FAIL pack_result lat=%0d data=%h n=%b exp lat=2 data=03FB n=0", n, res_data, res_neg); end
    retire();
    checks++; if (alu_op !== 3'd6 || alu_a !== 16'h0003 || alu_b !== 16'hFFFB) begin
      failures++; $display("FAIL alu_hold op=%0d a=%h b=%h exp op=6 a=0003 b=FFFB", alu_op, alu_a, alu_b); end
  endtask

  task automatic test_zero_shift();
    // res_ready asserted early must not shorten the pipeline
    res_ready = 1'b1;
    issue(mk(1'b0, 3'd7, 2'd2, 2'd0, 2'd0, 1'b0), 16'h0000);
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL early_ready_issue valid=%b exp=0", res_valid); end
    step();
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL early_ready_exec valid=%b exp=0", res_valid); end
    step();
    checks++; if (res_valid !== 1'b1 || res_data !== 16'h0000 || res_zero !== 1'b1 || res_neg !== 1'b0) begin
      failures++; $display("FAIL zero_result valid=%b data=%h z=%b n=%b exp valid=1 data=0000 z=1 n=0", res_valid, res_data, res_zero, res_neg); end
    step();
    res_ready = 1'b0;
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL zero_retire ready=%b exp=1", instr_ready); end
    issue(mk(1'b0, 3'd3, 2'd3, 2'd1, 2'd1, 1'b0), 16'h0000);
    wait_res(n);
    checks++; if (n !== 2 || res_data !== 16'hFFF8 || res_neg !== 1'b1 || res_zero !== 1'b0) begin
      failures++; $display("FAIL shift_result lat=%0d data=%h z=%b n=%b exp lat=2 data=FFF8 z=0 n=1", n, res_data, res_zero, res_neg); end
    retire();
  endtask

  task automatic test_backpressure();
    issue(mk(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0), 16'h8000);
    // keep offering a second load while the result is stalled
    instr = mk(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0); imm = 16'h1234; instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (res_valid !== 1'b1 || instr_ready !== 1'b0 || res_data !== 16'h8000 || res_neg !== 1'b1 || res_zero !== 1'b0) begin
        failures++; $display("FAIL stall%0d valid=%b ready=%b data=%h n=%b z=%b exp valid=1 ready=0 data=8000 n=1 z=0",
                             i, res_valid, instr_ready, res_data, res_neg, res_zero); end
      step();
    end
    instr_valid = 1'b0;
    dbg_sel = 2'd1; #1;
    checks++; if (dbg_data !== 16'hFFFB) begin failures++; $display("FAIL stall_no_accept r1=%h exp=FFFB", dbg_data); end
    retire();
    checks++; if (instr_ready !== 1'b1 || res_valid !== 1'b0) begin
      failures++; $display("FAIL stall_release ready=%b valid=%b exp ready=1 valid=0", instr_ready, res_valid); end
  endtask

  task automatic test_reset_mid();
    issue(mk(1'b0, 3'd2, 2'd3, 2'd1, 2'd1, 1'b0), 16'h0000);
    step(); // now in EXEC
    rst_n = 1'b0; #1;
    checks++; if (instr_ready !== 1'b1 || res_valid !== 1'b0 || alu_op !== 3'd7) begin
      failures++; $display("FAIL midrst_now ready=%b valid=%b op=%0d exp ready=1 valid=0 op=7", instr_ready, res_valid, alu_op); end
    dbg_sel = 2'd3; #1;
    checks++; if (dbg_data !== 16'h0000) begin failures++; $display("FAIL midrst_r3 got=%h exp=0000", dbg_data); end
    @(negedge clk); rst_n = 1'b1;
    step(); step();
    checks++; if (dbg_data !== 16'h0000 || res_valid !== 1'b0 || res_data !== 16'h0000) begin
      failures++; $display("FAIL midrst_after r3=%h valid=%b data=%h exp r3=0000 valid=0 data=0000", dbg_data, res_valid, res_data); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; instr_valid = 1'b0; instr = 16'd0; imm = 16'd0;
    res_ready = 1'b0; dbg_sel = 2'd0;
    @(posedge clk); #1;
    test_reset();
    test_load();
    test_add();
    test_neg_pack();
    test_zero_shift();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
